vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_gen_pkg.sv | 81 ++++++++
 rtl/vga_box_mover.sv | 56 +++++
 rtl/vga_pattern_gen.sv | 137 +++++++++++++
 tb/tb_vga_pattern_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pattern_gen_pkg.sv
// ============================================================================
// Module      : vga_pattern_gen_pkg
// Description : Shared types, RGB565 colour constants and helpers for the
//               VGA test-pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pattern_gen_pkg;

    // Displayed pattern; encoding is visible on the mode output.
    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_GRID  = 2'd1,
        MODE_BOX   = 2'd2,
        MODE_SOLID = 2'd3
    } mode_e;

    // RGB565 colours
    localparam logic [15:0] C_WHITE   = 16'hFFFF;
    localparam logic [15:0] C_YELLOW  = 16'hFFE0;
    localparam logic [15:0] C_CYAN    = 16'h07FF;
    localparam logic [15:0] C_GREEN   = 16'h07E0;
    localparam logic [15:0] C_MAGENTA = 16'hF81F;
    localparam logic [15:0] C_RED     = 16'hF800;
    localparam logic [15:0] C_BLUE    = 16'h001F;
    localparam logic [15:0] C_BLACK   = 16'h0000;

    // One axis of the bouncing box: position plus direction (0 = increasing).
    typedef struct packed {
        logic [11:0] pos;
        logic        dir;
    } axis_t;

    // Colour of vertical bar idx, left to right.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] col;
        col = C_BLACK;
        case (idx)
            3'd0:    col = C_WHITE;
            3'd1:    col = C_YELLOW;
            3'd2:    col = C_CYAN;
            3'd3:    col = C_GREEN;
            3'd4:    col = C_MAGENTA;
            3'd5:    col = C_RED;
            3'd6:    col = C_BLUE;
            default: col = C_BLACK;
        endcase
        return col;
    endfunction

    // Advance one axis by stp; reaching or passing a limit clamps there and
    // flips direction in the same update. Compare-before-subtract keeps the
    // decreasing path free of underflow.
    function automatic axis_t axis_next(input axis_t cur, input logic [11:0] lim,
                                        input logic [11:0] stp);
        axis_t       nxt;
        logic [12:0] up;
        nxt = cur;
        up  = {1'b0, cur.pos} + {1'b0, stp};
        if (!cur.dir) begin
            if (up >= {1'b0, lim}) begin
                nxt.pos = lim;
                nxt.dir = 1'b1;
            end else begin
                nxt.pos = up[11:0];
            end
        end else begin
            if (cur.pos <= stp) begin
                nxt.pos = 12'd0;
                nxt.dir = 1'b0;
            end else begin
                nxt.pos = cur.pos - stp;
            end
        end
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_box_mover.sv
// ============================================================================
// Module      : vga_box_mover
// Description : Bouncing-box position tracker, stepped once per frame tick.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_box_mover
    import vga_pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    output logic [11:0] box_x,
    output logic [11:0] box_y
);

    localparam logic [11:0] X_MAX = 12'(H_ACTIVE - BOX_SIZE);
    localparam logic [11:0] Y_MAX = 12'(V_ACTIVE - BOX_SIZE);
    localparam logic [11:0] STEP  = 12'(BOX_STEP);

    axis_t x_q, x_d;
    axis_t y_q, y_d;

    // Next position: move only on the frame tick, hold otherwise.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (frame_tick) begin
            x_d = axis_next(x_q, X_MAX, STEP);
            y_d = axis_next(y_q, Y_MAX, STEP);
        end
    end

    // Position/direction registers; reset to top-left moving right/down.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign box_x = x_q.pos;
    assign box_y = y_q.pos;

endmodule

`default_nettype wire

// File: rtl/vga_pattern_gen.sv
// ============================================================================
// Module      : vga_pattern_gen
// Description : VGA test-pattern generator (bars / grid / bouncing box /
//               solid) with frame-synchronous mode switching.
//               Optional macro VGA_PAT_BORDER_EN forces a white 1-pixel
//               border over every pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_pattern_gen
    import vga_pattern_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode_next,
    input  logic [11:0] h_addr,
    input  logic [11:0] v_addr,
    output logic [15:0] data_display,
    output logic [1:0]  mode,
    output logic        frame_tick
);

    localparam logic [11:0] H_LAST = 12'(H_ACTIVE - 1);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE - 1);
    localparam logic [11:0] BAR_W  = 12'(H_ACTIVE / 8);
    localparam logic [12:0] BOX_SZ = 13'(BOX_SIZE);

    mode_e       mode_q, mode_d;
    logic        pending_q, pending_d;
    logic        tick_q, tick_d;
    logic [15:0] pix_q, pix_d;
    logic [11:0] box_x, box_y;
    logic [11:0] bar_num;
    logic [2:0]  bar_idx;
    logic        in_box;

    // Box tracker steps on the same registered tick that drives mode changes.
    vga_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box_mover (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (tick_q),
        .box_x      (box_x),
        .box_y      (box_y)
    );

    // Mode state register.
    always_ff @(posedge clk) begin
        if (rst) mode_q <= MODE_BARS;
        else     mode_q <= mode_d;
    end

    // Mode next state: advance one step on a tick with a request pending.
    always_comb begin
        mode_d = mode_q;
        if (tick_q && pending_q) begin
            case (mode_q)
                MODE_BARS:  mode_d = MODE_GRID;
                MODE_GRID:  mode_d = MODE_BOX;
                MODE_BOX:   mode_d = MODE_SOLID;
                default:    mode_d = MODE_BARS;
            endcase
        end
    end

    // Mode output decode.
    always_comb begin
        mode = mode_q;
    end

    // Pending request: a tick consumes the old flag, but a request arriving
    // on that very cycle survives for the next tick.
    always_comb begin
        pending_d = pending_q | mode_next;
        if (tick_q) pending_d = mode_next;
    end

    // Last active pixel of the frame.
    assign tick_d = (h_addr == H_LAST) && (v_addr == V_LAST);

    // Pattern helpers: bar index (saturated at 7) and box hit test.
    always_comb begin
        bar_num = h_addr / BAR_W;
        bar_idx = (bar_num > 12'd7) ? 3'd7 : bar_num[2:0];
        in_box  = ({1'b0, h_addr} >= {1'b0, box_x}) &&
                  ({1'b0, h_addr} <  ({1'b0, box_x} + BOX_SZ)) &&
                  ({1'b0, v_addr} >= {1'b0, box_y}) &&
                  ({1'b0, v_addr} <  ({1'b0, box_y} + BOX_SZ));
    end

    // Pixel colour for the current address in the current mode.
    always_comb begin
        pix_d = C_BLACK;
        case (mode_q)
            MODE_BARS:  pix_d = bar_colour(bar_idx);
            MODE_GRID:  pix_d = ((h_addr[4:0] == 5'd0) || (v_addr[4:0] == 5'd0))
                                ? C_WHITE : C_BLACK;
            MODE_BOX:   pix_d = in_box ? C_RED : C_BLUE;
            default:    pix_d = C_GREEN;
        endcase
`ifdef VGA_PAT_BORDER_EN
        if ((h_addr == 12'd0) || (h_addr == H_LAST) ||
            (v_addr == 12'd0) || (v_addr == V_LAST)) begin
            pix_d = C_WHITE;
        end
`endif
    end

    // Output and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q     <= C_BLACK;
            tick_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            pix_q     <= pix_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
        end
    end

    assign data_display = pix_q;
    assign frame_tick   = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
// ============================================================================
// Module      : tb_vga_pattern_gen
// Description : Self-checking bench for vga_pattern_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode_next = 1'b0;
    logic [11:0] h_addr = '0;
    logic [11:0] v_addr = '0;
    logic [15:0] data_display;
    logic [1:0]  mode;
    logic        frame_tick;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic        adv;
        logic [11:0] h;
        logic [11:0] v;
        logic [15:0] exp_d;
        logic [1:0]  exp_m;
    } vec_t;

    vec_t tbl [16];

    vga_pattern_gen dut (
        .clk          (clk),
        .rst          (rst),
        .mode_next    (mode_next),
        .h_addr       (h_addr),
        .v_addr       (v_addr),
        .data_display (data_display),
        .mode         (mode),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;

    // Drive on the falling edge, return 1 time unit after the rising edge.
    task automatic step(input logic [11:0] h, input logic [11:0] v, input logic mn);
        @(negedge clk);
        h_addr    = h;
        v_addr    = v;
        mode_next = mn;
        @(posedge clk);
        #1;
    endtask

    // Present the last active pixel, then one more cycle so the tick is consumed.
    task automatic do_frame();
        step(12'd639, 12'd479, 1'b0);
        step(12'd300, 12'd100, 1'b0);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(12'd5, 12'd5, 1'b0);
        step(12'd5, 12'd5, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_border;

        // Table: bars (mode 0) then grid (mode 1, entered via one advance).
        tbl[0]  = '{1'b0, 12'd1,   12'd10, 16'hFFFF, 2'd0};
        tbl[1]  = '{1'b0, 12'd79,  12'd10, 16'hFFFF, 2'd0};
        tbl[2]  = '{1'b0, 12'd80,  12'd10, 16'hFFE0, 2'd0};
        tbl[3]  = '{1'b0, 12'd85,  12'd10, 16'hFFE0, 2'd0};
        tbl[4]  = '{1'b0, 12'd170, 12'd10, 16'h07FF, 2'd0};
        tbl[5]  = '{1'b0, 12'd250, 12'd10, 16'h07E0, 2'd0};
        tbl[6]  = '{1'b0, 12'd330, 12'd10, 16'hF81F, 2'd0};
        tbl[7]  = '{1'b0, 12'd410, 12'd10, 16'hF800, 2'd0};
        tbl[8]  = '{1'b0, 12'd490, 12'd10, 16'h001F, 2'd0};
        tbl[9]  = '{1'b0, 12'd638, 12'd10, 16'h0000, 2'd0};
        tbl[10] = '{1'b1, 12'd64,  12'd7,  16'hFFFF, 2'd1};
        tbl[11] = '{1'b0, 12'd65,  12'd7,  16'h0000, 2'd1};
        tbl[12] = '{1'b0, 12'd96,  12'd64, 16'hFFFF, 2'd1};
        tbl[13] = '{1'b0, 12'd33,  12'd33, 16'h0000, 2'd1};
        tbl[14] = '{1'b0, 12'd100, 12'd96, 16'hFFFF, 2'd1};
        tbl[15] = '{1'b0, 12'd31,  12'd200, 16'h0000, 2'd1};

        // Reset state.
        rst = 1'b1;
        step(12'd85, 12'd10, 1'b0);
        step(12'd85, 12'd10, 1'b0);
        chk("reset_data", data_display, 16'h0000);
        chk("reset_mode", {14'd0, mode}, 16'd0);
        chk("reset_tick", {15'd0, frame_tick}, 16'd0);
        rst = 1'b0;

        // One-cycle latency on the second bar.
        step(12'd85, 12'd10, 1'b0);
        chk("latency_bar1", data_display, 16'hFFE0);
        chk("latency_mode", {14'd0, mode}, 16'd0);

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].adv) begin
                step(12'd300, 12'd100, 1'b1);
                do_frame();
            end
            step(tbl[i].h, tbl[i].v, 1'b0);
            chk($sformatf("vec%0d_data", i), data_display, tbl[i].exp_d);
            chk($sformatf("vec%0d_mode", i), {14'd0, mode}, {14'd0, tbl[i].exp_m});
        end

        // Reset mid-frame discards a pending request.
        do_reset();
        step(12'd10, 12'd10, 1'b1);
        do_reset();
        do_frame();
        chk("reset_drops_pending", {14'd0, mode}, 16'd0);

        // Several requests in one frame advance exactly once, at the tick.
        step(12'd10, 12'd10, 1'b1);
        step(12'd20, 12'd10, 1'b0);
        step(12'd30, 12'd10, 1'b1);
        step(12'd40, 12'd10, 1'b1);
        chk("multi_req_before_tick", {14'd0, mode}, 16'd0);
        step(12'd639, 12'd479, 1'b0);
        chk("tick_asserted", {15'd0, frame_tick}, 16'd1);
        chk("mode_on_tick_cycle", {14'd0, mode}, 16'd0);
        step(12'd0, 12'd0, 1'b0);
        chk("tick_one_cycle", {15'd0, frame_tick}, 16'd0);
        chk("multi_req_after_tick", {14'd0, mode}, 16'd1);
        do_frame();
        chk("multi_req_next_frame", {14'd0, mode}, 16'd1);

        // Request coincident with the tick waits for the following tick.
        step(12'd639, 12'd479, 1'b0);
        step(12'd300, 12'd100, 1'b1);
        chk("coincident_no_advance", {14'd0, mode}, 16'd1);
        do_frame();
        chk("coincident_later_advance", {14'd0, mode}, 16'd2);

        // Box bounce: from reset, reach BOX mode, 304 ticks total.
        do_reset();
        step(12'd300, 12'd100, 1'b1);
        do_frame();
        step(12'd300, 12'd100, 1'b1);
        do_frame();
        for (int f = 0; f < 302; f++) do_frame();
        // Box now at x=608 (moving left), y=288.
        step(12'd608, 12'd288, 1'b0);
        chk("box304_corner", data_display, 16'hF800);
        step(12'd607, 12'd288, 1'b0);
        chk("box304_left_out", data_display, 16'h001F);
        step(12'd620, 12'd319, 1'b0);
        chk("box304_bottom_in", data_display, 16'hF800);
        step(12'd620, 12'd320, 1'b0);
        chk("box304_bottom_out", data_display, 16'h001F);
        do_frame();
        // Box now at x=606, y=286.
        step(12'd606, 12'd286, 1'b0);
        chk("box305_corner", data_display, 16'hF800);
        step(12'd605, 12'd286, 1'b0);
        chk("box305_left_out", data_display, 16'h001F);
        step(12'd637, 12'd300, 1'b0);
        chk("box305_right_in", data_display, 16'hF800);
        step(12'd638, 12'd300, 1'b0);
        chk("box305_right_out", data_display, 16'h001F);

        // SOLID mode and right-edge border behaviour.
        step(12'd300, 12'd100, 1'b1);
        do_frame();
        chk("solid_mode", {14'd0, mode}, 16'd3);
        step(12'd300, 12'd200, 1'b0);
        chk("solid_centre", data_display, 16'h07E0);
`ifdef VGA_PAT_BORDER_EN
        exp_border = 16'hFFFF;
`else
        exp_border = 16'h07E0;
`endif
        step(12'd639, 12'd200, 1'b0);
        chk("solid_right_edge", data_display, exp_border);

        // Wrap back to BARS.
        step(12'd300, 12'd100, 1'b1);
        do_frame();
        chk("wrap_to_bars", {14'd0, mode}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
